// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage iterative multiply/divide unit:
// operation encodings, control states and the default datapath width.
package muldiv_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } md_state_e;

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Operand/control bundle between the ID/EX pipeline stage and the
// multiply/divide unit, plus the HI/LO results and the stall back to hazard logic.
interface ex_muldiv_unit_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] busA;
  logic [WIDTH-1:0] busB;
  logic             kill;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, busA, busB, kill,
    input  busy, stall, done, hi, lo
  );

  modport slave (
    input  start, op, busA, busB, kill,
    output busy, stall, done, hi, lo
  );

endinterface

// File: rtl/md_signfix.sv
// Conditional two's-complement negate, used both to take operand magnitudes
// and to restore the sign of products, quotients and remainders.
module md_signfix #(
  parameter int WIDTH = 32
) (
  input  logic             neg_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  assign dout_o = neg_i ? -din_i : din_i;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU: one magnitude bit per cycle in a shared
// 2*WIDTH accumulator, then a single sign-fix cycle that writes HI/LO.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  ex_muldiv_unit_if.slave  md
);

  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  md_state_e          state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   mcand_q;
  logic               is_div_q;
  logic               neg_prod_q;
  logic               neg_rem_q;
  logic               div0_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  // Operand decode and magnitudes, only consumed on the IDLE start edge
  md_op_e           op_in;
  logic             signed_op;
  logic             div_op;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  assign op_in     = md_op_e'(md.op);
  assign signed_op = (op_in == OP_MULT) || (op_in == OP_DIV);
  assign div_op    = (op_in == OP_DIV)  || (op_in == OP_DIVU);

  md_signfix #(.WIDTH(WIDTH)) u_abs_a (
    .neg_i  (signed_op & md.busA[WIDTH-1]),
    .din_i  (md.busA),
    .dout_o (abs_a)
  );

  md_signfix #(.WIDTH(WIDTH)) u_abs_b (
    .neg_i  (signed_op & md.busB[WIDTH-1]),
    .din_i  (md.busB),
    .dout_o (abs_b)
  );

  // Multiply step: add into the upper half with a carry bit, then shift right
  logic [WIDTH:0] mul_sum;
  assign mul_sum = acc_q[0] ? ({1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q})
                            : {1'b0, acc_q[2*WIDTH-1:WIDTH]};

  // Divide step: {rem,quot} shifted left; rem_ext is the WIDTH+1 bit partial remainder
  logic [WIDTH:0]   rem_ext;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_sub;
  assign rem_ext = acc_q[2*WIDTH-1:WIDTH-1];
  assign rem_ge  = rem_ext[WIDTH] | (rem_ext[WIDTH-1:0] >= mcand_q);
  assign rem_sub = rem_ext[WIDTH-1:0] - mcand_q;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    acc_d = acc_q;
    if (is_div_q) begin
      if (rem_ge) acc_d = {rem_sub, acc_q[WIDTH-2:0], 1'b1};
      else        acc_d = {rem_ext[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      acc_d = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  // Sign restoration; a zero divisor keeps the all-ones quotient, while the
  // remainder fix turns |A| back into the raw dividend on its own.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  md_signfix #(.WIDTH(2*WIDTH)) u_fix_prod (
    .neg_i  (neg_prod_q),
    .din_i  (acc_q),
    .dout_o (prod_fix)
  );

  md_signfix #(.WIDTH(WIDTH)) u_fix_quot (
    .neg_i  (neg_prod_q & ~div0_q),
    .din_i  (acc_q[WIDTH-1:0]),
    .dout_o (quot_fix)
  );

  md_signfix #(.WIDTH(WIDTH)) u_fix_rem (
    .neg_i  (neg_rem_q),
    .din_i  (acc_q[2*WIDTH-1:WIDTH]),
    .dout_o (rem_fix)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      is_div_q   <= 1'b0;
      neg_prod_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      div0_q     <= 1'b0;
      done_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (md.start && !md.kill) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            is_div_q   <= div_op;
            neg_prod_q <= signed_op & (md.busA[WIDTH-1] ^ md.busB[WIDTH-1]);
            neg_rem_q  <= signed_op & md.busA[WIDTH-1];
            div0_q     <= div_op & (md.busB == '0);
            acc_q      <= div_op ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
            mcand_q    <= div_op ? abs_b : abs_a;
          end
        end
        RUN: begin
          if (md.kill) begin
            state_q <= IDLE;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(ITER - 1)) state_q <= FIX;
          end
        end
        FIX: begin
          state_q <= IDLE;
          if (!md.kill) begin
            done_q <= 1'b1;
            if (is_div_q) begin
              hi_q <= rem_fix;
              lo_q <= quot_fix;
            end else begin
              hi_q <= prod_fix[2*WIDTH-1:WIDTH];
              lo_q <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign md.busy  = (state_q != IDLE);
  assign md.stall = (state_q != IDLE) || md.start;
  assign md.done  = done_q;
  assign md.hi    = hi_q;
  assign md.lo    = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed corner cases, random ops
// against an arithmetic reference model, and kill/reset/ignored-start boundaries.
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic clk;
  logic rst_n;

  ex_muldiv_unit_if #(.WIDTH(W)) md ();

  ex_muldiv_unit #(.WIDTH(W), .ITER(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .md    (md)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference result as {hi, lo}, straight from integer arithmetic
  function automatic logic [63:0] model(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
    longint pa, pb;
    int sa, sb, q, r;
    case (op)
      OP_MULT: begin
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        return 64'(pa * pb);
      end
      OP_MULTU: return {32'b0, a} * {32'b0, b};
      OP_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sa = $signed(a);
        sb = $signed(b);
        q  = sa / sb;
        r  = sa % sb;
        return {r, q};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Starts an op in the current cycle and returns in the done cycle.
  // glitch > 0 pulses a conflicting start that many cycles into the op.
  task automatic run_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input string tag, input int glitch);
    logic [63:0] exp;
    int lat, st;
    bit seen;
    exp = model(op, a, b);
    md.op    = op;
    md.busA  = a;
    md.busB  = b;
    md.kill  = 1'b0;
    md.start = 1'b1;
    #1;
    st = md.stall ? 1 : 0;
    lat  = 0;
    seen = 1'b0;
    while (lat < 40 && !seen) begin
      @(posedge clk);
      #1;
      md.start = 1'b0;
      lat++;
      if (md.done) seen = 1'b1;
      else if (md.stall) st++;
      if (lat == glitch) begin
        md.start = 1'b1;
        md.op    = OP_MULTU;
        md.busA  = 32'hDEAD_BEEF;
        md.busB  = 32'h0000_0003;
      end
    end
    check({tag, "_latency"}, lat, 34);
    check({tag, "_stall_cycles"}, st, 34);
    if (seen) begin
      check({tag, "_hi"}, md.hi, exp[63:32]);
      check({tag, "_lo"}, md.lo, exp[31:0]);
      check({tag, "_busy_in_done"}, md.busy, 0);
      last_hi = exp[63:32];
      last_lo = exp[31:0];
    end
  endtask

  initial begin
    int extra;
    md_op_e rop;
    logic [31:0] ra, rb;

    rst_n    = 1'b0;
    md.start = 1'b0;
    md.kill  = 1'b0;
    md.op    = OP_MULT;
    md.busA  = '0;
    md.busB  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  md.busy, 0);
    check("rst_done",  md.done, 0);
    check("rst_stall", md.stall, 0);
    check("rst_hi",    md.hi, 0);
    check("rst_lo",    md.lo, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases, issued back to back (each start lands in the prior done cycle)
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", 0);
    check("multu_max_hi_const", md.hi, 32'hFFFF_FFFE);
    check("multu_max_lo_const", md.lo, 32'h0000_0001);
    run_op(OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, "mult_neg3x7", 0);
    run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, "mult_minxmin", 0);
    check("mult_minxmin_hi_const", md.hi, 32'h4000_0000);
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, "div_m7_2", 0);
    run_op(OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, "div_7_m2", 0);
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_overflow", 0);
    run_op(OP_DIVU,  32'd100,       32'd7,         "divu_100_7", 0);
    check("divu_100_7_lo_const", md.lo, 32'd14);
    run_op(OP_DIVU,  32'h1234_5678, 32'h0,         "divu_by0", 0);
    run_op(OP_DIV,   32'hF000_0001, 32'h0,         "div_by0_neg", 0);

    // Randomized ops, biased toward zero/small/all-ones divisors
    for (int i = 0; i < 24; i++) begin
      rop = md_op_e'($urandom_range(0, 3));
      ra  = $urandom;
      if ($urandom_range(0, 3) == 0) ra = $urandom_range(0, 255);
      case ($urandom_range(0, 7))
        0:       rb = 32'h0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb, $sformatf("rand%0d", i), 0);
    end

    // Start pulsed mid-operation is ignored and not queued
    run_op(OP_MULT, 32'h0001_2345, 32'hFFFF_0010, "ignored_start", 5);
    extra = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (md.done || md.busy) extra++;
    end
    check("ignored_start_no_second_op", extra, 0);

    // Kill in RUN: no done, HI/LO untouched, idle on the next cycle
    md.op = OP_MULTU; md.busA = $urandom; md.busB = $urandom; md.start = 1'b1;
    @(posedge clk);
    #1;
    md.start = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    md.kill = 1'b1;
    @(posedge clk);
    #1;
    md.kill = 1'b0;
    check("kill_busy", md.busy, 0);
    check("kill_done", md.done, 0);
    check("kill_hi", md.hi, last_hi);
    check("kill_lo", md.lo, last_lo);
    extra = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (md.done) extra++;
    end
    check("kill_no_done", extra, 0);

    // Kill together with start in IDLE drops the start
    md.start = 1'b1; md.kill = 1'b1;
    @(posedge clk);
    #1;
    md.start = 1'b0; md.kill = 1'b0;
    check("kill_start_busy", md.busy, 0);
    check("kill_start_hi", md.hi, last_hi);

    // Asynchronous reset in the middle of an operation
    run_op(OP_MULTU, 32'd3, 32'd5, "pre_reset", 0);
    md.op = OP_DIV; md.busA = 32'h7654_3210; md.busB = 32'd9; md.start = 1'b1;
    @(posedge clk);
    #1;
    md.start = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    check("mid_busy_before_reset", md.busy, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_hi",   md.hi, 0);
    check("async_rst_lo",   md.lo, 0);
    check("async_rst_busy", md.busy, 0);
    check("async_rst_done", md.done, 0);
    #2;
    rst_n = 1'b1;
    last_hi = '0;
    last_lo = '0;
    @(posedge clk);
    #1;
    check("post_rst_idle", md.busy, 0);
    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd10, "post_reset_op", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
